// File: rtl/shift_ram_pkg.sv
// Shared constants for the 11-channel shift-delay RAM and its scheduler.
// Holds the channel count, data/select widths, the RAM read latency,
// each channel's delay depth and each channel's circular address window.
// The RAM block and the bench use the same definitions.
package shift_ram_pkg;

  localparam int NCH    = 11;  // channels, fixed by the RAM address map
  localparam int DW     = 8;   // data width
  localparam int SELW   = 4;   // channel select width
  localparam int RD_LAT = 1;   // RAM read latency in clk cycles
  localparam int FILLW  = 8;   // fill counter width
  localparam int ADDRW  = 11;  // 2k-deep RAM address width

  // Delay depth of channel i is 17*(i+1).
  localparam logic [FILLW-1:0] DEPTH [0:NCH-1] = '{
    8'd17, 8'd34, 8'd51, 8'd68, 8'd85, 8'd102,
    8'd119, 8'd136, 8'd153, 8'd170, 8'd187
  };

  // Window i starts at the sum of the depths of all lower channels.
  localparam logic [ADDRW-1:0] BASE_ADDR [0:NCH-1] = '{
    11'd0, 11'd17, 11'd51, 11'd102, 11'd170, 11'd255,
    11'd357, 11'd476, 11'd612, 11'd765, 11'd935
  };

  // Last address of each window; the channel pointer wraps back to BASE_ADDR.
  localparam logic [ADDRW-1:0] WRAP_ADDR [0:NCH-1] = '{
    11'd16, 11'd50, 11'd101, 11'd169, 11'd254, 11'd356,
    11'd475, 11'd611, 11'd764, 11'd934, 11'd1121
  };

  // One entry of the output tag pipeline.
  typedef struct packed {
    logic            valid;
    logic [SELW-1:0] ch;
  } tag_t;

endpackage

// File: rtl/shift_ram_scheduler_rr_arbiter.sv
// Pointer-based round-robin arbiter.
// The search starts at the pointer and wraps modulo N, so the first
// requester at or after the pointer wins. After a grant the pointer moves
// to winner+1; otherwise (no request, or pause) it holds.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req        : per-requester request
//   pause      : 1 suppresses all grants and freezes the pointer
//   gnt        : one-hot grant (combinational)
//   grant      : any grant this cycle
//   winner     : index of the granted requester (0 when none)
module rr_arbiter
  import shift_ram_pkg::*;
#(
  parameter int N  = NCH,
  parameter int IW = SELW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          pause,
  output logic [N-1:0]  gnt,
  output logic          grant,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] ptr_next_s;
  logic [IW:0]   sum_s;
  logic [IW-1:0] idx_s;
  logic          hit_s;

  // Rotating priority search: the first hit after the pointer wins.
  always_comb begin
    gnt    = '0;
    grant  = 1'b0;
    winner = '0;
    sum_s  = '0;
    idx_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr_r} + (IW+1)'(k);
      if (sum_s >= (IW+1)'(N)) begin
        idx_s = IW'(sum_s - (IW+1)'(N));
      end else begin
        idx_s = sum_s[IW-1:0];
      end
      hit_s      = !pause && !grant && req[idx_s];
      gnt[idx_s] = hit_s;
      winner     = hit_s ? idx_s : winner;
      grant      = grant | hit_s;
    end
  end

  // Next pointer: one past the winner, wrapping N-1 to 0.
  always_comb begin
    ptr_next_s = ptr_r;
    if (grant) begin
      if (winner == IW'(N - 1)) begin
        ptr_next_s = '0;
      end else begin
        ptr_next_s = winner + IW'(1);
      end
    end else begin
      ptr_next_s = ptr_r;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_next_s;
    end
  end

endmodule

// File: rtl/shift_ram_scheduler.sv
// Round-robin scheduler sharing the 11-channel shift-delay RAM between 11
// byte requesters. Each cycle at most one channel is granted; its push, sel
// and din go straight to the RAM (zero-cycle grant). Once a channel's delay
// line is full, each further grant also reads the RAM, and the delayed byte
// is tagged with its channel RD_LAT cycles later.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req        : per-channel request (byte available)
//   req_data   : per-channel byte, channel i at [i*DW +: DW]
//   pause      : 1 blocks new grants
//   gnt, push  : one-hot grant / RAM write strobe (identical)
//   sel, din   : RAM channel select and write byte; hold when idle
//   ram_re     : RAM read enable, only for primed channels
//   out_valid  : RAM dout carries a delayed byte
//   out_ch     : channel of that byte
//   primed     : per-channel delay line full
module shift_ram_scheduler
  import shift_ram_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      req,
  input  logic [NCH*DW-1:0]   req_data,
  input  logic                pause,
  output logic [NCH-1:0]      gnt,
  output logic [NCH-1:0]      push,
  output logic [SELW-1:0]     sel,
  output logic [DW-1:0]       din,
  output logic                ram_re,
  output logic                out_valid,
  output logic [SELW-1:0]     out_ch,
  output logic [NCH-1:0]      primed
);

  logic              block_s;
  logic [NCH-1:0]    gnt_s;
  logic              grant_s;
  logic [SELW-1:0]   winner_s;
  logic [DW-1:0]     din_mux_s;
  logic [SELW-1:0]   sel_r;
  logic [DW-1:0]     din_r;
  logic [FILLW-1:0]  fill_r      [NCH];
  logic [FILLW-1:0]  fill_next_s [NCH];
  logic [NCH-1:0]    primed_r;
  logic [NCH-1:0]    primed_next_s;
  tag_t              tag_pipe_r  [RD_LAT];

  // Reset also blocks grants so nothing reaches the RAM while it is cleared.
  assign block_s = pause | reset;

  rr_arbiter #(
    .N  (NCH),
    .IW (SELW)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .pause  (block_s),
    .gnt    (gnt_s),
    .grant  (grant_s),
    .winner (winner_s)
  );

  // Byte of the winning channel.
  always_comb begin
    din_mux_s = '0;
    for (int i = 0; i < NCH; i++) begin
      din_mux_s = (winner_s == SELW'(i)) ? req_data[i*DW +: DW] : din_mux_s;
    end
  end

  // RAM-facing controls; sel/din fall back to the shadow copy when idle so
  // the RAM address never glitches between grants.
  always_comb begin
    gnt  = gnt_s;
    push = gnt_s;
    if (grant_s) begin
      sel    = winner_s;
      din    = din_mux_s;
      ram_re = primed_r[winner_s];
    end else begin
      sel    = sel_r;
      din    = din_r;
      ram_re = 1'b0;
    end
  end

  // Shadow of the last granted sel/din.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_r <= '0;
      din_r <= '0;
    end else if (grant_s) begin
      sel_r <= winner_s;
      din_r <= din_mux_s;
    end else begin
      sel_r <= sel_r;
      din_r <= din_r;
    end
  end

  // Fill counters saturate at the channel depth; primed mirrors "full".
  always_comb begin
    primed_next_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_s[i] && (fill_r[i] < DEPTH[i])) begin
        fill_next_s[i] = fill_r[i] + 8'd1;
      end else begin
        fill_next_s[i] = fill_r[i];
      end
      primed_next_s[i] = (fill_next_s[i] == DEPTH[i]);
    end
  end

  // Fill and primed registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        fill_r[i] <= '0;
      end
      primed_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        fill_r[i] <= fill_next_s[i];
      end
      primed_r <= primed_next_s;
    end
  end

  assign primed = primed_r;

  // Tag pipeline matching the RAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tag_pipe_r[s] <= '0;
      end
    end else begin
      tag_pipe_r[0] <= '{valid: ram_re, ch: sel};
      for (int s = 1; s < RD_LAT; s++) begin
        tag_pipe_r[s] <= tag_pipe_r[s-1];
      end
    end
  end

  assign out_valid = tag_pipe_r[RD_LAT-1].valid;
  assign out_ch    = tag_pipe_r[RD_LAT-1].ch;

endmodule

// File: tb/tb_shift_ram_scheduler.sv
// Self-checking bench for shift_ram_scheduler: directed scenarios with
// literal expectations plus a randomized run, all outputs compared every
// cycle against a behavioural model of the scheduling rules.
module tb_shift_ram_scheduler;

  localparam int NCH = 11;
  localparam int DW  = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      req;
  logic [NCH*DW-1:0]   req_data;
  logic                pause;
  logic [NCH-1:0]      gnt;
  logic [NCH-1:0]      push;
  logic [3:0]          sel;
  logic [DW-1:0]       din;
  logic                ram_re;
  logic                out_valid;
  logic [3:0]          out_ch;
  logic [NCH-1:0]      primed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_ram_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .pause     (pause),
    .gnt       (gnt),
    .push      (push),
    .sel       (sel),
    .din       (din),
    .ram_re    (ram_re),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .primed    (primed)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] rand_data();
    logic [NCH*DW-1:0] d;
    for (int i = 0; i < NCH; i++) d[i*DW +: DW] = 8'($urandom);
    return d;
  endfunction

  // ---------------- behavioural model ----------------
  // Channel depth is 17*(ch+1); a channel is primed once it has seen that
  // many pushes since reset. Pointer = one past the last winner.
  int m_ptr = 0;
  int m_fill [NCH];
  int m_last_sel = 0;
  int m_last_din = 0;
  bit m_prev_re = 1'b0;
  int m_prev_sel = 0;

  initial for (int i = 0; i < NCH; i++) m_fill[i] = 0;

  always @(negedge clk) begin : model_cmp
    int w;
    int c;
    logic [NCH-1:0] e_gnt;
    logic [NCH-1:0] e_pr;
    int e_sel;
    int e_din;
    bit e_re;
    if (reset) begin
      m_ptr = 0;
      for (int i = 0; i < NCH; i++) m_fill[i] = 0;
      m_last_sel = 0;
      m_last_din = 0;
      m_prev_re  = 1'b0;
      m_prev_sel = 0;
    end
    w = -1;
    if (!reset && !pause) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (w < 0 && req[c]) w = c;
      end
    end
    e_gnt = '0;
    if (w >= 0) e_gnt[w] = 1'b1;
    e_sel = (w >= 0) ? w : m_last_sel;
    e_din = (w >= 0) ? int'(req_data[w*DW +: DW]) : m_last_din;
    e_re  = (w >= 0) && (m_fill[w] == 17 * (w + 1));
    for (int i = 0; i < NCH; i++) e_pr[i] = (m_fill[i] == 17 * (i + 1));

    chk("gnt",       32'(gnt),       32'(e_gnt));
    chk("push",      32'(push),      32'(e_gnt));
    chk("sel",       32'(sel),       32'(e_sel));
    chk("din",       32'(din),       32'(e_din));
    chk("ram_re",    32'(ram_re),    32'(e_re));
    chk("out_valid", 32'(out_valid), 32'(m_prev_re));
    chk("out_ch",    32'(out_ch),    32'(m_prev_sel));
    chk("primed",    32'(primed),    32'(e_pr));

    if (!reset) begin
      if (w >= 0) begin
        if (m_fill[w] < 17 * (w + 1)) m_fill[w]++;
        m_ptr      = (w + 1) % NCH;
        m_last_sel = w;
        m_last_din = e_din;
      end
      m_prev_re  = e_re;
      m_prev_sel = e_sel;
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle's inputs just after the clock edge, then return a little
  // later so literal checks sample settled outputs.
  task automatic drive(input logic [NCH-1:0] r, input logic p, input logic rs,
                       input logic [NCH*DW-1:0] d);
    @(posedge clk);
    #1;
    req      = r;
    pause    = p;
    reset    = rs;
    req_data = d;
    #2;
  endtask

  // 18 pushes of bytes 1..18 into channel 0, then one idle cycle.
  task automatic ch0_prime_test();
    logic [NCH*DW-1:0] d;
    for (int k = 1; k <= 18; k++) begin
      d = rand_data();
      d[7:0] = 8'(k);
      drive(11'h001, 1'b0, 1'b0, d);
      chk("ch0_gnt",    32'(gnt),    32'h001);
      chk("ch0_din",    32'(din),    32'(k));
      chk("ch0_ram_re", 32'(ram_re), 32'(k == 18));
      if (k == 17) chk("ch0_primed_before", 32'(primed[0]), 32'd0);
      if (k == 18) chk("ch0_primed_after",  32'(primed[0]), 32'd1);
    end
    drive(11'h000, 1'b0, 1'b0, rand_data());
    chk("tag_valid", 32'(out_valid), 32'd1);
    chk("tag_ch",    32'(out_ch),    32'd0);
    chk("idle_re",   32'(ram_re),    32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    pause    = 1'b0;
    req_data = '0;
    #2;
    chk("rst_gnt",       32'(gnt),       32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_primed",    32'(primed),    32'd0);
    drive(11'h000, 1'b0, 1'b1, rand_data());
    drive(11'h000, 1'b0, 1'b0, rand_data());

    // Idle: nothing moves.
    for (int k = 0; k < 20; k++) begin
      drive(11'h000, 1'b0, 1'b0, rand_data());
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_sel", 32'(sel), 32'd0);
      chk("idle_din", 32'(din), 32'd0);
    end

    // All channels requesting: strict rotation from channel 0.
    for (int k = 0; k < 12; k++) begin
      drive(11'h7FF, 1'b0, 1'b0, rand_data());
      chk("rot_gnt", 32'(gnt), 32'(1) << (k % NCH));
      chk("rot_sel", 32'(sel), 32'(k % NCH));
    end

    // Channel 0 priming from a clean reset.
    drive(11'h000, 1'b0, 1'b1, rand_data());
    drive(11'h000, 1'b0, 1'b0, rand_data());
    ch0_prime_test();

    // Pause freezes grants and pointer; resume after last winner (0).
    for (int k = 0; k < 5; k++) begin
      drive(11'h7FF, 1'b1, 1'b0, rand_data());
      chk("pause_gnt", 32'(gnt), 32'd0);
    end
    drive(11'h7FF, 1'b0, 1'b0, rand_data());
    chk("resume_gnt", 32'(gnt), 32'h002);

    // Channels 3 and 10 alternate; each reads only once primed.
    drive(11'h000, 1'b0, 1'b1, rand_data());
    drive(11'h000, 1'b0, 1'b0, rand_data());
    for (int k = 0; k < 400; k++) begin
      drive(11'h408, 1'b0, 1'b0, rand_data());
      if (k % 2 == 0) begin
        chk("alt_gnt3",  32'(gnt),    32'h008);
        chk("ch3_re",    32'(ram_re), 32'((k / 2 + 1) >= 69));
      end else begin
        chk("alt_gnt10", 32'(gnt),    32'h400);
        chk("ch10_re",   32'(ram_re), 32'(((k + 1) / 2) >= 188));
      end
    end

    // Reset mid-operation with the tag pipeline loaded.
    @(posedge clk);
    #1;
    chk("pre_reset_ov", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt",    32'(gnt),       32'd0);
    chk("mid_rst_re",     32'(ram_re),    32'd0);
    chk("mid_rst_ov",     32'(out_valid), 32'd0);
    chk("mid_rst_och",    32'(out_ch),    32'd0);
    chk("mid_rst_sel",    32'(sel),       32'd0);
    chk("mid_rst_din",    32'(din),       32'd0);
    chk("mid_rst_primed", 32'(primed),    32'd0);
    drive(11'h408, 1'b0, 1'b1, rand_data());
    drive(11'h000, 1'b0, 1'b0, rand_data());
    chk("post_rst_ov", 32'(out_valid), 32'd0);
    ch0_prime_test();

    // Randomized traffic, pause and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      logic [NCH-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'h7FF;
      drive(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 999) == 0), rand_data());
    end
    drive(11'h000, 1'b0, 1'b0, rand_data());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
